// File: rtl/tqvp_bus_pkg.sv
// Shared definitions for the TQVP peripheral bus initiator: transfer size codes,
// controller state encoding and the size-based data masking helper.
package tqvp_bus_pkg;

  localparam logic [1:0] SIZE_8    = 2'b00;
  localparam logic [1:0] SIZE_16   = 2'b01;
  localparam logic [1:0] SIZE_32   = 2'b10;
  localparam logic [1:0] SIZE_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RESP
  } state_e;

  // Zero every byte lane above the transfer size.
  function automatic logic [31:0] size_mask(input logic [31:0] data, input logic [1:0] size);
    logic [31:0] res;
    case (size)
      SIZE_8:  res = {24'h0, data[7:0]};
      SIZE_16: res = {16'h0, data[15:0]};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/tqvp_bus_initiator.sv
// Single-outstanding command-to-peripheral bus initiator with read timeout and
// a latched rising-edge interrupt flag. Every output comes straight from a flop.
module tqvp_bus_initiator
  import tqvp_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [5:0]  per_addr,
  output logic [31:0] per_wdata,
  output logic [1:0]  per_write_n,
  output logic [1:0]  per_read_n,
  input  logic [31:0] per_rdata,
  input  logic        per_ready,
  input  logic        per_irq,
  output logic        irq_pending,
  input  logic        irq_ack
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [5:0]  per_addr_q, per_addr_d;
  logic [31:0] per_wdata_q, per_wdata_d;
  logic [1:0]  per_write_n_q, per_write_n_d;
  logic [1:0]  per_read_n_q, per_read_n_d;
  logic [1:0]  size_q, size_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        irq_prev_q, irq_prev_d;
  logic        irq_pending_q, irq_pending_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      per_addr_q    <= '0;
      per_wdata_q   <= '0;
      per_write_n_q <= SIZE_NONE;
      per_read_n_q  <= SIZE_NONE;
      size_q        <= SIZE_NONE;
      cnt_q         <= '0;
      irq_prev_q    <= 1'b0;
      irq_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_rdata_q   <= rsp_rdata_d;
      per_addr_q    <= per_addr_d;
      per_wdata_q   <= per_wdata_d;
      per_write_n_q <= per_write_n_d;
      per_read_n_q  <= per_read_n_d;
      size_q        <= size_d;
      cnt_q         <= cnt_d;
      irq_prev_q    <= irq_prev_d;
      irq_pending_q <= irq_pending_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_err_d     = rsp_err_q;
    rsp_rdata_d   = rsp_rdata_q;
    per_addr_d    = per_addr_q;
    per_wdata_d   = per_wdata_q;
    per_write_n_d = per_write_n_q;
    per_read_n_d  = per_read_n_q;
    size_d        = size_q;
    cnt_d         = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          per_addr_d  = cmd_addr;
          per_wdata_d = size_mask(cmd_wdata, cmd_size);
          size_d      = cmd_size;
          if (cmd_size == SIZE_NONE) begin
            // Illegal size never touches the peripheral.
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (cmd_write) begin
            state_d       = ST_WRITE;
            per_write_n_d = cmd_size;
          end else begin
            state_d      = ST_READ;
            per_read_n_d = cmd_size;
            cnt_d        = '0;
          end
        end
      end
      ST_WRITE: begin
        state_d       = ST_RESP;
        per_write_n_d = SIZE_NONE;
        rsp_valid_d   = 1'b1;
        rsp_err_d     = 1'b0;
        rsp_rdata_d   = '0;
      end
      ST_READ: begin
        // Ready is checked before the timeout so a last-cycle ready still succeeds.
        if (per_ready) begin
          state_d      = ST_RESP;
          per_read_n_d = SIZE_NONE;
          rsp_valid_d  = 1'b1;
          rsp_err_d    = 1'b0;
          rsp_rdata_d  = size_mask(per_rdata, size_q);
        end else if (cnt_q == TO_LAST) begin
          state_d      = ST_RESP;
          per_read_n_d = SIZE_NONE;
          rsp_valid_d  = 1'b1;
          rsp_err_d    = 1'b1;
          rsp_rdata_d  = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
  end

  // A fresh edge outranks a simultaneous acknowledge.
  always_comb begin
    irq_prev_d = per_irq;
    if (per_irq && !irq_prev_q)
      irq_pending_d = 1'b1;
    else if (irq_ack)
      irq_pending_d = 1'b0;
    else
      irq_pending_d = irq_pending_q;
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign per_addr    = per_addr_q;
  assign per_wdata   = per_wdata_q;
  assign per_write_n = per_write_n_q;
  assign per_read_n  = per_read_n_q;
  assign irq_pending = irq_pending_q;

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// Randomized transaction-level bench for tqvp_bus_initiator against a
// cycle-count reference model of command latency, strobes and responses.
module tb_tqvp_bus_initiator;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_write, rsp_ready, per_ready, per_irq, irq_ack;
  logic [1:0]  cmd_size;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata, per_rdata;
  logic        cmd_ready, rsp_valid, rsp_err, irq_pending;
  logic [31:0] rsp_rdata, per_wdata;
  logic [5:0]  per_addr;
  logic [1:0]  per_write_n, per_read_n;

  int nvec = 0;
  int nerr = 0;

  tqvp_bus_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .per_addr(per_addr), .per_wdata(per_wdata), .per_write_n(per_write_n),
    .per_read_n(per_read_n), .per_rdata(per_rdata), .per_ready(per_ready),
    .per_irq(per_irq), .irq_pending(irq_pending), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] msk(input logic [31:0] d, input logic [1:0] s);
    if (s == 2'd0) return d & 32'h0000_00FF;
    if (s == 2'd1) return d & 32'h0000_FFFF;
    return d;
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // k: READ cycle (1-based) in which per_ready is raised; k > T means never.
  task automatic run_txn(input logic wr, input logic [1:0] sz, input logic [5:0] ad,
                         input logic [31:0] wd, input int k, input int hold,
                         input logic [31:0] rdfix);
    int wr_cyc, rd_cyc, rsp_cyc, bad, exp_lat, exp_wr, exp_rd, kk;
    logic [31:0] rd_cap, exp_rdata, r0;
    logic exp_err, e0;
    wr_cyc = 0; rd_cyc = 0; rsp_cyc = 0; bad = 0; rd_cap = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_size = sz; cmd_addr = ad; cmd_wdata = wd;
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    nxt();
    cmd_valid = 1'b0; cmd_write = $urandom; cmd_addr = 6'($urandom); cmd_wdata = $urandom;
    cmd_size = 2'($urandom);
    for (int c = 1; c <= T + 6 && rsp_cyc == 0; c++) begin
      if (c > 1) nxt();
      if (per_write_n != 2'b11) begin
        wr_cyc++;
        if (per_write_n != sz || per_addr != ad || per_wdata != msk(wd, sz)) bad++;
      end
      if (per_read_n != 2'b11) begin
        rd_cyc++;
        if (per_read_n != sz || per_addr != ad) bad++;
      end
      if (cmd_ready) bad++;
      if (rsp_valid) begin
        rsp_cyc = c;
        rsp_ready = 1'b0;
        per_ready = $urandom;
      end else begin
        rsp_ready = $urandom;
        per_rdata = (c == k && rdfix != 0) ? rdfix : $urandom;
        per_ready = wr ? 1'($urandom) : (c == k);
        if (!wr && c == k) rd_cap = per_rdata;
      end
    end
    kk = (k <= T) ? k : T;
    if (sz == 2'b11) begin
      exp_lat = 1; exp_wr = 0; exp_rd = 0; exp_err = 1'b1; exp_rdata = 0;
    end else if (wr) begin
      exp_lat = 2; exp_wr = 1; exp_rd = 0; exp_err = 1'b0; exp_rdata = 0;
    end else begin
      exp_lat = kk + 1; exp_wr = 0; exp_rd = kk;
      exp_err = (k > T); exp_rdata = (k > T) ? 32'd0 : msk(rd_cap, sz);
    end
    chk("rsp_latency", rsp_cyc, exp_lat);
    chk("write_strobe_cycles", wr_cyc, exp_wr);
    chk("read_strobe_cycles", rd_cyc, exp_rd);
    chk("strobe_payload_busy", bad, 0);
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    if (rsp_cyc != 0) begin
      r0 = rsp_rdata; e0 = rsp_err; bad = 0;
      for (int h = 0; h < hold; h++) begin
        per_ready = $urandom;
        nxt();
        if (!rsp_valid || rsp_rdata != r0 || rsp_err != e0 || cmd_ready ||
            per_write_n != 2'b11 || per_read_n != 2'b11) bad++;
      end
      chk("rsp_hold_stable", bad, 0);
      rsp_ready = 1'b1;
      nxt();
      rsp_ready = 1'b0; per_ready = 1'b0;
      chk("rsp_done_valid", {31'b0, rsp_valid}, 32'd0);
      chk("cmd_ready_back", {31'b0, cmd_ready}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_p, prev, ni, na;
    int bad;
    rst_n = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_size = 0; cmd_addr = 0; cmd_wdata = 0;
    rsp_ready = 0; per_ready = 0; per_rdata = 0; per_irq = 0; irq_ack = 0;
    #23;
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_strobes", {28'b0, per_write_n, per_read_n}, 32'hF);
    chk("rst_addr_wdata", {per_addr, per_wdata[25:0]} | {26'b0, per_wdata[31:26]}, 32'd0);
    chk("rst_rsp_payload", rsp_rdata | {31'b0, rsp_err}, 32'd0);
    chk("rst_irq_pending", {31'b0, irq_pending}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    nxt();
    chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Directed cases
    run_txn(1'b1, 2'b10, 6'h00, 32'hA000_0012, 1, 0, 0);
    run_txn(1'b0, 2'b00, 6'h28, 32'h0, 3, 1, 32'h1234_56AB);
    run_txn(1'b0, 2'b01, 6'h11, 32'h0, T + 1, 0, 0);
    run_txn(1'b0, 2'b01, 6'h12, 32'h0, T, 2, 32'hCAFE_BEEF);
    run_txn(1'b0, 2'b10, 6'h13, 32'h0, 1, 0, 0);
    run_txn(1'b1, 2'b00, 6'h3F, 32'hDEAD_BEEF, 1, 3, 0);
    run_txn(1'b1, 2'b01, 6'h05, 32'h8765_4321, 1, 0, 0);
    run_txn(1'b1, 2'b11, 6'h07, 32'hFFFF_FFFF, 1, 5, 0);
    run_txn(1'b0, 2'b11, 6'h08, 32'h0, 1, 5, 0);

    for (int i = 0; i < 60; i++)
      run_txn(1'($urandom), 2'($urandom), 6'($urandom), $urandom,
              $urandom_range(1, T + 2), $urandom_range(0, 4), 0);

    // Interrupt: edge together with ack still sets, later ack clears, level does not re-set
    nxt();
    per_irq = 1'b1; irq_ack = 1'b1;
    nxt();
    irq_ack = 1'b0;
    chk("irq_set_beats_ack", {31'b0, irq_pending}, 32'd1);
    nxt();
    chk("irq_held", {31'b0, irq_pending}, 32'd1);
    irq_ack = 1'b1;
    nxt();
    irq_ack = 1'b0;
    chk("irq_ack_clears", {31'b0, irq_pending}, 32'd0);
    nxt();
    chk("irq_level_no_reset", {31'b0, irq_pending}, 32'd0);

    exp_p = 1'b0; prev = 1'b1; bad = 0;
    for (int i = 0; i < 200; i++) begin
      ni = $urandom; na = ($urandom_range(0, 3) == 0);
      per_irq = ni; irq_ack = na;
      if (ni && !prev) exp_p = 1'b1;
      else if (na) exp_p = 1'b0;
      prev = ni;
      nxt();
      if (irq_pending !== exp_p) bad++;
    end
    chk("irq_random_seq", bad, 0);
    per_irq = 1'b0; irq_ack = 1'b0;

    // Reset in the middle of a read
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'b01; cmd_addr = 6'h2A;
    chk("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    nxt();
    cmd_valid = 1'b0; per_ready = 1'b0;
    nxt(); nxt();
    chk("mid_rst_read_active", {30'b0, per_read_n}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_strobe_idle", {30'b0, per_read_n}, 32'd3);
    chk("mid_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      nxt();
      if (rsp_valid || per_read_n != 2'b11) bad++;
    end
    chk("mid_rst_silent", bad, 0);
    chk("mid_rst_cmd_ready_back", {31'b0, cmd_ready}, 32'd1);
    run_txn(1'b0, 2'b10, 6'h01, 32'h0, 2, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/tqvp_bus_initiator.md
TQVP_BUS_INITIATOR -- requirements
Module: tqvp_bus_initiator

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, read cycles (1..255) to wait for per_ready before aborting.
REQ-002 clk  in  1  clock.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accept.
REQ-006 cmd_write  in  1  1=write, 0=read.
REQ-007 cmd_size  in  2  00=8b, 01=16b, 10=32b, 11=illegal.
REQ-008 cmd_addr  in  6  peripheral address.
REQ-009 cmd_wdata  in  32  write data.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  response consumed.
REQ-012 rsp_rdata  out  32  read data, zero-extended to size.
REQ-013 rsp_err  out  1  1=illegal size or read timeout.
REQ-014 per_addr  out  6  peripheral address.
REQ-015 per_wdata  out  32  peripheral write data.
REQ-016 per_write_n  out  2  11=idle, else size code; peripheral write strobe.
REQ-017 per_read_n  out  2  11=idle, else size code; peripheral read request.
REQ-018 per_rdata  in  32  peripheral read data.
REQ-019 per_ready  in  1  peripheral read-data valid.
REQ-020 per_irq  in  1  peripheral interrupt level.
REQ-021 irq_pending  out  1  latched rising edge of per_irq.
REQ-022 irq_ack  in  1  clears irq_pending.

Function
REQ-023 FSM states IDLE, WRITE, READ, RESP; all outputs registered.
REQ-024 IDLE: cmd_ready=1; handshake cmd_valid&cmd_ready registers addr/size/wdata/write; cmd_ready=0 in all other states (one outstanding transaction).
REQ-025 Illegal size: IDLE->RESP directly, rsp_err=1, rsp_rdata=0, per strobes stay 11.
REQ-026 Write: per_write_n=size for exactly one cycle (WRITE), then RESP with rsp_err=0, rsp_rdata=0; per_ready ignored.
REQ-027 per_wdata: bits above size zeroed (8b: [31:8]=0; 16b: [31:16]=0).
REQ-028 Read: per_read_n=size held every READ cycle; per_ready sampled each READ cycle; on per_ready=1 capture per_rdata masked to size, rsp_err=0, go RESP, per_read_n=11 next cycle.
REQ-029 Read timeout: 8-bit counter cleared on READ entry; after TIMEOUT_CYCLES READ cycles without per_ready -> RESP, rsp_err=1, rsp_rdata=0.
REQ-030 per_ready in the final timeout cycle: ready wins, no error.
REQ-031 Latency: accept cycle N -> strobe cycle N+1 -> rsp_valid cycle N+2 (write, or read with per_ready at N+1).
REQ-032 RESP: rsp_valid=1, payload stable until rsp_ready=1; handshake returns to IDLE next cycle; rsp_ready while rsp_valid=0 ignored.
REQ-033 per_addr/per_wdata retain last command value when idle; only strobes define activity.
REQ-034 irq_pending set on per_irq 0->1 (registered previous value); irq_ack clears; simultaneous set and ack -> set wins.

Reset
REQ-035 Reset: state=IDLE, cmd_ready=0 during reset then 1, rsp_valid=0, rsp_err=0, rsp_rdata=0, per_write_n=per_read_n=11, per_addr=0, per_wdata=0, timeout counter=0, irq_pending=0, per_irq history=0.
REQ-036 Reset mid-transaction aborts silently: strobes 11 immediately, no response produced.

Structure
REQ-037 Package tqvp_bus_pkg holds size codes (SIZE_8=00, SIZE_16=01, SIZE_32=10, SIZE_NONE=11) and the FSM state enum.
REQ-038 Single module, no sub-module; size masking as a package function.

Verification
REQ-039 Write 32b addr 0x00 data 0xA0000012 -> per_write_n=10 for one cycle with per_wdata=0xA0000012, rsp_valid two cycles after accept, rsp_err=0.
REQ-040 Read 8b addr 0x28, per_ready=1 after 3 cycles, per_rdata=0x1234_56AB -> per_read_n=00 for 3 cycles, rsp_rdata=0x000000AB, rsp_err=0.
REQ-041 Read 16b, per_ready never high, TIMEOUT_CYCLES=16 -> per_read_n=01 exactly 16 cycles, rsp_err=1, rsp_rdata=0; per_ready in cycle 16 -> no error.
REQ-042 cmd_size=11 -> no strobe activity, rsp_err=1; rsp_ready held low 5 cycles -> rsp stable, cmd_ready=0 throughout.
REQ-043 per_irq pulse 0->1 with irq_ack in same cycle -> irq_pending=1; later irq_ack -> 0; rst_n low during READ -> per_read_n=11 at once, no rsp_valid.
